// File: rtl/ras_ctrl_if.sv
// Fetch/RAS-side signal bundle for ras_ctrl.
// master: fetch stage, RAS and retire logic driving the controller.
// slave:  the controller itself.
// Optional stats counters are present only when RAS_CTRL_STATS_EN is defined.
interface ras_ctrl_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_is_call;
  logic            if_is_ret;
  logic [XLEN-1:0] if_pc;
  logic            if_stall;
  logic            ret_hit;
  logic [XLEN-1:0] ret_target;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_din;
  logic [XLEN-1:0] ras_dout;
  logic            commit_valid;
  logic            flush;
  logic            busy;
`ifdef RAS_CTRL_STATS_EN
  logic [15:0]     ovf_cnt;
  logic [15:0]     unf_cnt;
  logic [15:0]     rcv_cnt;
`endif

  modport master (
    output if_valid, if_is_call, if_is_ret, if_pc, ras_dout, commit_valid, flush,
    input  if_stall, ret_hit, ret_target, ras_push, ras_pop, ras_din, busy
`ifdef RAS_CTRL_STATS_EN
    , input ovf_cnt, unf_cnt, rcv_cnt
`endif
  );

  modport slave (
    input  if_valid, if_is_call, if_is_ret, if_pc, ras_dout, commit_valid, flush,
    output if_stall, ret_hit, ret_target, ras_push, ras_pop, ras_din, busy
`ifdef RAS_CTRL_STATS_EN
    , output ovf_cnt, unf_cnt, rcv_cnt
`endif
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack speculation controller.
// Converts fetch call/return hints into RAS push/pop commands, logs every
// accepted op, and on flush replays the inverse of each uncommitted op,
// newest first, one per cycle (the RAS has no pointer-restore port).
// Optional: define RAS_CTRL_STATS_EN to add overflow/underflow/recovery counters.
// The XLEN parameter must match the one used for the connected ras_ctrl_if.
module ras_ctrl #(
  parameter int LOG_DEPTH = 8,
  parameter int RAS_DEPTH = 16,
  parameter int XLEN      = 32
) (
  input  logic        clk,
  input  logic        rst,
  ras_ctrl_if.slave   io_bus
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEP_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic {S_IDLE, S_RECOVER} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_SWAP = 2'd3} op_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] w_tailPrev;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countAfterCommit;
  logic [DEP_W-1:0] r_depth;
  op_t              r_logType [LOG_DEPTH];
  logic [XLEN-1:0]  r_logData [LOG_DEPTH];

  logic             w_isOp;
  logic             w_idle;
  logic             w_full;
  logic             w_accept;
  logic             w_commit;
  logic             w_depthZero;
  logic             w_depthFull;
  op_t              w_opType;
  op_t              w_recType;
  logic [XLEN-1:0]  w_recData;
  logic [XLEN-1:0]  w_linkAddr;
  logic [XLEN-1:0]  w_entryData;

  assign w_isOp             = io_bus.if_valid & (io_bus.if_is_call | io_bus.if_is_ret);
  assign w_idle             = (r_state == S_IDLE);
  assign w_full             = (r_count == CNT_W'(LOG_DEPTH));
  assign w_accept           = w_isOp & w_idle & ~io_bus.flush & ~w_full;
  assign w_commit           = w_idle & io_bus.commit_valid & (r_count != '0);
  assign w_countAfterCommit = r_count - CNT_W'(w_commit);
  assign w_depthZero        = (r_depth == '0);
  assign w_depthFull        = (r_depth == DEP_W'(RAS_DEPTH));
  assign w_tailPrev         = r_tail - PTR_W'(1);
  assign w_recType          = r_logType[w_tailPrev];
  assign w_recData          = r_logData[w_tailPrev];
  assign w_linkAddr         = io_bus.if_pc + XLEN'(4);
  assign w_entryData        = ((w_opType == OP_POP) || (w_opType == OP_SWAP)) ? io_bus.ras_dout : '0;

  // Classify the incoming fetch op against the current RAS occupancy.
  always_comb begin
    w_opType = OP_NOP;
    if (io_bus.if_is_call && io_bus.if_is_ret) begin
      w_opType = w_depthZero ? OP_PUSH : OP_SWAP;
    end else if (io_bus.if_is_call) begin
      w_opType = w_depthFull ? OP_NOP : OP_PUSH;
    end else if (io_bus.if_is_ret) begin
      w_opType = w_depthZero ? OP_NOP : OP_POP;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next state: enter recovery when a flush leaves uncommitted entries, leave after the last one.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (io_bus.flush && (w_countAfterCommit != '0)) w_nextState = S_RECOVER;
      S_RECOVER: if (r_count <= CNT_W'(1)) w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  // Outputs: forward commands for accepted ops in IDLE, inverse commands while recovering.
  always_comb begin
    io_bus.if_stall   = w_isOp & (~w_idle | w_full | io_bus.flush);
    io_bus.busy       = ~w_idle;
    io_bus.ret_hit    = 1'b0;
    io_bus.ret_target = '0;
    io_bus.ras_push   = 1'b0;
    io_bus.ras_pop    = 1'b0;
    io_bus.ras_din    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_opType)
            OP_PUSH: begin
              io_bus.ras_push = 1'b1;
              io_bus.ras_din  = w_linkAddr;
            end
            OP_POP: begin
              io_bus.ras_pop    = 1'b1;
              io_bus.ret_hit    = 1'b1;
              io_bus.ret_target = io_bus.ras_dout;
            end
            OP_SWAP: begin
              io_bus.ras_push   = 1'b1;
              io_bus.ras_pop    = 1'b1;
              io_bus.ras_din    = w_linkAddr;
              io_bus.ret_hit    = 1'b1;
              io_bus.ret_target = io_bus.ras_dout;
            end
            default: ;
          endcase
        end
      end
      S_RECOVER: begin
        case (w_recType)
          OP_PUSH: io_bus.ras_pop = 1'b1;
          OP_POP: begin
            io_bus.ras_push = 1'b1;
            io_bus.ras_din  = w_recData;
          end
          OP_SWAP: begin
            io_bus.ras_push = 1'b1;
            io_bus.ras_pop  = 1'b1;
            io_bus.ras_din  = w_recData;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Log pointers, entry count and tracked RAS depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_depth <= '0;
    end else if (r_state == S_RECOVER) begin
      if (r_count != '0) begin
        r_tail  <= w_tailPrev;
        r_count <= r_count - CNT_W'(1);
        if ((w_recType == OP_PUSH) && !w_depthZero) r_depth <= r_depth - DEP_W'(1);
        if ((w_recType == OP_POP)  && !w_depthFull) r_depth <= r_depth + DEP_W'(1);
      end
    end else begin
      r_head  <= r_head + PTR_W'(w_commit);
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_commit);
      if (w_accept) begin
        r_tail <= r_tail + PTR_W'(1);
        if ((w_opType == OP_PUSH) && !w_depthFull) r_depth <= r_depth + DEP_W'(1);
        if ((w_opType == OP_POP)  && !w_depthZero) r_depth <= r_depth - DEP_W'(1);
      end
    end
  end

  // Log storage: type plus the RAS top that a pop or swap destroyed.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_logType[r_tail] <= w_opType;
      r_logData[r_tail] <= w_entryData;
    end
  end

`ifdef RAS_CTRL_STATS_EN
  logic w_callNop;
  logic w_retNop;

  assign w_callNop = w_accept & io_bus.if_is_call & ~io_bus.if_is_ret & (w_opType == OP_NOP);
  assign w_retNop  = w_accept & io_bus.if_is_ret & ~io_bus.if_is_call & (w_opType == OP_NOP);

  // Saturating event counters for overflowing calls, underflowing returns and recovery cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_bus.ovf_cnt <= '0;
      io_bus.unf_cnt <= '0;
      io_bus.rcv_cnt <= '0;
    end else begin
      if (w_callNop && (io_bus.ovf_cnt != 16'hFFFF)) io_bus.ovf_cnt <= io_bus.ovf_cnt + 16'd1;
      if (w_retNop  && (io_bus.unf_cnt != 16'hFFFF)) io_bus.unf_cnt <= io_bus.unf_cnt + 16'd1;
      if (!w_idle   && (io_bus.rcv_cnt != 16'hFFFF)) io_bus.rcv_cnt <= io_bus.rcv_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Testbench for ras_ctrl: a behavioural 16-entry RAS sits on the command port,
// and a stack-snapshot reference model predicts every output and the RAS contents.
module tb_ras_ctrl;
  localparam int LOG_DEPTH = 8;
  localparam int RAS_DEPTH = 16;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [4:0]       d;
    logic [15:0][31:0] s;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ras_ctrl_if #(.XLEN(XLEN)) bus ();

  ras_ctrl #(.LOG_DEPTH(LOG_DEPTH), .RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAS driven by the controller's commands; reset together with the controller.
  snap_t      ras;
  logic [3:0] rasTop;
  assign rasTop       = 4'(ras.d - 5'd1);
  assign bus.ras_dout = (ras.d != 5'd0) ? ras.s[rasTop] : '0;

  always @(posedge clk) begin
    if (rst) begin
      ras <= '0;
    end else if (bus.ras_push && bus.ras_pop) begin
      if (ras.d != 5'd0) ras.s[rasTop] <= bus.ras_din;
    end else if (bus.ras_push) begin
      if (ras.d < 5'd16) begin
        ras.s[ras.d[3:0]] <= bus.ras_din;
        ras.d             <= ras.d + 5'd1;
      end
    end else if (bus.ras_pop) begin
      if (ras.d != 5'd0) begin
        ras.s[rasTop] <= '0;
        ras.d         <= ras.d - 5'd1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: expected stack, log of pre-op snapshots, pending recovery.
  snap_t mStack;
  snap_t mRestore;
  snap_t mLog[$];
  int    mRem;

  logic        cV, cC, cR, cCm, cFl;
  logic [31:0] cPc;
  logic        sStall, sHit, sPush, sPop, sBusy;
  logic [31:0] sTgt, sDin;
  logic [1:0]  recCmd [8];
  logic [31:0] recDin [8];

  function automatic logic [31:0] stackTop(snap_t st);
    return (st.d != 5'd0) ? st.s[4'(st.d - 5'd1)] : 32'h0;
  endfunction

  function automatic snap_t applyOp(snap_t st, logic call, logic ret, logic [31:0] pc);
    snap_t n = st;
    if (call && ret && st.d != 5'd0) begin
      n.s[4'(st.d - 5'd1)] = pc + 32'd4;
    end else if (call && (ret || st.d < 5'd16)) begin
      n.s[st.d[3:0]] = pc + 32'd4;
      n.d            = st.d + 5'd1;
    end else if (ret && st.d != 5'd0) begin
      n.s[4'(st.d - 5'd1)] = '0;
      n.d                  = st.d - 5'd1;
    end
    return n;
  endfunction

  task automatic compareValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit busyM, op, acc, expPush, expPop;
    int n;
    busyM = (mRem > 0);
    op    = cV && (cC || cR);
    n     = mLog.size();
    acc   = op && !busyM && !cFl && (n < LOG_DEPTH);
    compareValue("if_stall", sStall, op && (busyM || n == LOG_DEPTH || cFl));
    compareValue("busy", sBusy, busyM);
    compareValue("ret_hit", sHit, acc && cR && mStack.d != 5'd0);
    if (!busyM) begin
      expPush = acc && cC && (cR || mStack.d < 5'd16);
      expPop  = acc && cR && (mStack.d != 5'd0);
      compareValue("ras_push", sPush, expPush);
      compareValue("ras_pop", sPop, expPop);
      compareValue("ret_target", sTgt, expPop ? stackTop(mStack) : 32'h0);
      if (expPush) compareValue("ras_din", sDin, cPc + 32'd4);
      checks++;
      assert (ras === mStack) else begin
        errors++;
        $error("[TB] FAIL ras_state: observed=%h expected=%h", ras, mStack);
      end
    end
  endtask

  task automatic modelUpdate();
    bit acc;
    int n;
    if (mRem > 0) begin
      mRem--;
      if (mRem == 0) mStack = mRestore;
    end else begin
      n   = mLog.size();
      acc = cV && (cC || cR) && !cFl && (n < LOG_DEPTH);
      if (cCm && n > 0) void'(mLog.pop_front());
      if (cFl) begin
        if (mLog.size() > 0) begin
          mRem     = mLog.size();
          mRestore = mLog[0];
          mLog.delete();
        end
      end else if (acc) begin
        mLog.push_back(mStack);
        mStack = applyOp(mStack, cC, cR, cPc);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic c, input logic r,
                               input logic [31:0] pc, input logic cm, input logic fl);
    cV = v; cC = c; cR = r; cPc = pc; cCm = cm; cFl = fl;
    bus.if_valid     = v;
    bus.if_is_call   = c;
    bus.if_is_ret    = r;
    bus.if_pc        = pc;
    bus.commit_valid = cm;
    bus.flush        = fl;
    @(negedge clk);
    sStall = bus.if_stall;
    sHit   = bus.ret_hit;
    sTgt   = bus.ret_target;
    sPush  = bus.ras_push;
    sPop   = bus.ras_pop;
    sDin   = bus.ras_din;
    sBusy  = bus.busy;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    cV = 0; cC = 0; cR = 0; cPc = 0; cCm = 0; cFl = 0;
    bus.if_valid = 0; bus.if_is_call = 0; bus.if_is_ret = 0;
    bus.if_pc = '0; bus.commit_valid = 0; bus.flush = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst    = 1'b0;
    mStack = '0;
    mLog.delete();
    mRem   = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && mLog.size() > 0; i++) applyStimulus(0, 0, 0, 32'h0, 1, 0);
  endtask

  task automatic waitRecovery(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 0, 0);
      if (!sBusy) break;
      if (n < 8) begin
        recCmd[n] = {sPush, sPop};
        recDin[n] = sDin;
      end
      n++;
    end
  endtask

  // Safety net so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by a randomized phase, all checked against the model.
  initial begin
    int n;
    doReset(2);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    compareValue("reset_busy", sBusy, 0);
    compareValue("reset_ras_depth", ras.d, 0);

    applyStimulus(1, 1, 0, 32'h100, 0, 0);
    applyStimulus(1, 1, 0, 32'h200, 0, 0);
    applyStimulus(1, 1, 0, 32'h300, 0, 0);
    applyStimulus(1, 0, 1, 32'h0, 1, 0);
    compareValue("ret1_target", sTgt, 32'h304);
    compareValue("ret1_hit", sHit, 1);
    applyStimulus(1, 0, 1, 32'h0, 1, 0);
    compareValue("ret2_target", sTgt, 32'h204);
    applyStimulus(1, 0, 1, 32'h0, 1, 0);
    compareValue("ret3_target", sTgt, 32'h104);
    applyStimulus(1, 0, 1, 32'h0, 1, 0);
    compareValue("ret4_hit", sHit, 0);
    compareValue("ret4_target", sTgt, 32'h0);
    drain();
    compareValue("depth_after_rets", ras.d, 0);

    applyStimulus(1, 1, 0, 32'h100, 0, 0);
    drain();
    applyStimulus(1, 1, 0, 32'h400, 0, 0);
    applyStimulus(1, 0, 1, 32'h0, 0, 0);
    compareValue("spec_ret_target", sTgt, 32'h404);
    applyStimulus(1, 1, 0, 32'h500, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitRecovery(n);
    compareValue("flush3_busy_cycles", n, 3);
    compareValue("rcv_cmd0", recCmd[0], 2'b01);
    compareValue("rcv_cmd1", recCmd[1], 2'b10);
    compareValue("rcv_din1", recDin[1], 32'h404);
    compareValue("rcv_cmd2", recCmd[2], 2'b01);
    applyStimulus(1, 0, 1, 32'h0, 0, 0);
    compareValue("post_flush_ret", sTgt, 32'h104);
    drain();

    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 32'h1000 + 32'(i * 16), 1, 0);
    applyStimulus(1, 1, 0, 32'h900, 1, 0);
    compareValue("ovf_call_no_push", sPush, 0);
    applyStimulus(1, 0, 1, 32'h0, 1, 0);
    compareValue("ovf_ret_target", sTgt, 32'h10F4);
    doReset(2);

    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 32'h2000 + 32'(i * 16), 0, 0);
    applyStimulus(1, 1, 0, 32'h3000, 0, 0);
    compareValue("full_stall", sStall, 1);
    applyStimulus(1, 1, 0, 32'h3000, 1, 0);
    compareValue("full_commit_stall", sStall, 1);
    applyStimulus(1, 1, 0, 32'h3000, 0, 0);
    compareValue("after_commit_accept", sStall, 0);
    compareValue("after_commit_push", sPush, 1);
    doReset(2);

    applyStimulus(1, 1, 0, 32'h100, 0, 0);
    drain();
    applyStimulus(1, 1, 1, 32'h600, 0, 0);
    compareValue("swap_target", sTgt, 32'h104);
    compareValue("swap_din", sDin, 32'h604);
    compareValue("swap_new_top", bus.ras_dout, 32'h604);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitRecovery(n);
    compareValue("swap_busy_cycles", n, 1);
    compareValue("swap_undo_cmd", recCmd[0], 2'b11);
    compareValue("swap_undo_din", recDin[0], 32'h104);
    applyStimulus(1, 0, 1, 32'h0, 0, 0);
    compareValue("swap_post_ret", sTgt, 32'h104);
    drain();

    applyStimulus(1, 1, 0, 32'h700, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 1, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    compareValue("flush_commit_no_busy", sBusy, 0);

    applyStimulus(1, 1, 0, 32'h800, 0, 0);
    applyStimulus(1, 1, 0, 32'h810, 0, 0);
    applyStimulus(1, 1, 0, 32'h820, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    compareValue("mid_recover_busy", sBusy, 1);
    doReset(1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    compareValue("rst_abort_busy", sBusy, 0);
    compareValue("rst_abort_depth", ras.d, 0);
    applyStimulus(1, 0, 1, 32'h0, 0, 0);
    compareValue("rst_abort_ret_hit", sHit, 0);

    doReset(2);
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < 45,
                    {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
